// File: rtl/esync_pkg.sv
// Shared types and defaults for the out-of-synch monitor.
// The lock state enum is 2 bits wide so that state registers stay compact,
// and cnt_width() sizes counters that must hold values up to WINDOW.
package esync_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        LOCK    = 2'b01,
        SUSPECT = 2'b10
    } esync_state_t;

    localparam int DEF_METRIC_W  = 3;
    localparam int DEF_STAGE_W   = 4;
    localparam int DEF_MIN_STAGE = 3;
    localparam int DEF_WINDOW    = 16;
    localparam int DEF_ERR_LIMIT = 4;
    localparam int DEF_GOOD_WIN  = 2;
    localparam int DEF_NPHASE    = 2;

    // Number of bits needed to hold any count from 0 to window inclusive.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/esync_window.sv
// Qualified-sample window counter for the out-of-synch monitor.
// Counts qualified samples into fixed-size windows and counts bad samples
// in each window, saturating at the error limit. On the sample that closes
// a window it raises close for that cycle, and fail alongside it when the
// window (closing sample included) reached the error limit.
module esync_window
    import esync_pkg::*;
#(
    parameter int WINDOW    = DEF_WINDOW,
    parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic sample,
    input  logic bad,
    output logic close,
    output logic fail
);

    localparam int CW = cnt_width(WINDOW);
    localparam logic [CW-1:0] LAST_IDX  = CW'(WINDOW - 1);
    localparam logic [CW-1:0] LIMIT_VAL = CW'(ERR_LIMIT);

    logic [CW-1:0] win_cnt;
    logic [CW-1:0] bad_cnt;
    logic [CW-1:0] bad_next;

    // Bad count including the current sample, so the closing sample itself
    // contributes to the verdict; saturates once the limit is reached.
    always_comb begin
        bad_next = bad_cnt;
        if (sample && bad && (bad_cnt != LIMIT_VAL)) begin
            bad_next = bad_cnt + CW'(1);
        end
        close = sample && (win_cnt == LAST_IDX);
        fail  = close && (bad_next >= LIMIT_VAL);
    end

    // Window position and bad count; both restart at every window close,
    // on clear, and on reset. Non-qualified cycles hold the counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_cnt <= '0;
            bad_cnt <= '0;
        end else if (clear) begin
            win_cnt <= '0;
            bad_cnt <= '0;
        end else if (sample) begin
            if (close) begin
                win_cnt <= '0;
                bad_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + CW'(1);
                bad_cnt <= bad_next;
            end
        end
    end

endmodule

// File: rtl/esync_monitor.sv
// Out-of-synch monitor for the Viterbi decoder family.
// Watches the normalised best-path metric on each accepted write, counts
// bad samples per window, and runs a HUNT/LOCK/SUSPECT lock machine. Each
// failed window in HUNT, and a second consecutive failure once locked,
// advances the symbol-phase hypothesis and pulses resync so the
// depuncture/branch-alignment logic can try the next phase.
module esync_monitor
    import esync_pkg::*;
#(
    parameter int METRIC_W  = DEF_METRIC_W,
    parameter int STAGE_W   = DEF_STAGE_W,
    parameter int MIN_STAGE = DEF_MIN_STAGE,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int ERR_LIMIT = DEF_ERR_LIMIT,
    parameter int GOOD_WIN  = DEF_GOOD_WIN,
    parameter int NPHASE    = DEF_NPHASE
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sync_clr,
    input  logic                      we,
    input  logic [STAGE_W-1:0]        stage,
    input  logic [METRIC_W-1:0]       metric,
    input  logic [METRIC_W-1:0]       thresh,
    output logic                      error,
    output logic                      locked,
    output logic                      resync,
    output logic [$clog2(NPHASE)-1:0] phase,
    output logic [7:0]                resync_cnt
);

    localparam int PW = $clog2(NPHASE);
    localparam int GW = cnt_width(GOOD_WIN);
    localparam logic [STAGE_W-1:0] MIN_STAGE_VAL = STAGE_W'(MIN_STAGE);
    localparam logic [PW-1:0]      LAST_PHASE    = PW'(NPHASE - 1);
    localparam logic [GW-1:0]      GOOD_LAST     = GW'(GOOD_WIN - 1);

    esync_state_t  state_q;
    esync_state_t  state_next;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_next;
    logic [PW-1:0] phase_next;
    logic          advance;
    logic          qualified;
    logic          bad;
    logic          win_close;
    logic          win_fail;

    // Samples before the trellis has filled are ignored; a bad sample is a
    // qualified one whose metric strictly exceeds the threshold.
    always_comb begin
        qualified = we && (stage >= MIN_STAGE_VAL);
        bad       = qualified && (metric > thresh);
    end

    esync_window #(
        .WINDOW    (WINDOW),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_window (
        .clock  (clock),
        .reset  (reset),
        .clear  (sync_clr),
        .sample (qualified),
        .bad    (bad),
        .close  (win_close),
        .fail   (win_fail)
    );

    // Lock machine next state; it only moves on a window close. A phase
    // advance is requested on any failure that leaves (or keeps) us in HUNT.
    always_comb begin
        state_next = state_q;
        good_next  = good_cnt;
        advance    = 1'b0;
        if (win_close) begin
            case (state_q)
                HUNT: begin
                    if (win_fail) begin
                        advance   = 1'b1;
                        good_next = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        state_next = LOCK;
                        good_next  = '0;
                    end else begin
                        good_next = good_cnt + GW'(1);
                    end
                end
                LOCK: begin
                    if (win_fail) begin
                        state_next = SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (win_fail) begin
                        state_next = HUNT;
                        advance    = 1'b1;
                        good_next  = '0;
                    end else begin
                        state_next = LOCK;
                    end
                end
                default: begin
                    state_next = HUNT;
                    good_next  = '0;
                end
            endcase
        end
        phase_next = phase;
        if (advance) begin
            phase_next = (phase == LAST_PHASE) ? '0 : phase + PW'(1);
        end
    end

    // Lock state and passing-window count; sync_clr restarts the hunt.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= HUNT;
            good_cnt <= '0;
        end else if (sync_clr) begin
            state_q  <= HUNT;
            good_cnt <= '0;
        end else begin
            state_q  <= state_next;
            good_cnt <= good_next;
        end
    end

    // Registered outputs: per-sample error flag, one-cycle resync pulse,
    // phase hypothesis and a saturating count of resync requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error      <= 1'b0;
            resync     <= 1'b0;
            phase      <= '0;
            resync_cnt <= '0;
        end else if (sync_clr) begin
            error      <= 1'b0;
            resync     <= 1'b0;
            phase      <= '0;
            resync_cnt <= '0;
        end else begin
            error  <= bad;
            resync <= advance;
            phase  <= phase_next;
            if (advance && (resync_cnt != 8'hFF)) begin
                resync_cnt <= resync_cnt + 8'd1;
            end
        end
    end

    // Locked is a pure decode of the registered state, so it changes on the
    // same edge as phase and resync.
    assign locked = (state_q != HUNT);

endmodule

// File: tb/tb_esync_monitor.sv
// Scoreboard testbench for esync_monitor.
// The stimulus process drives one input vector per clock and pushes the
// expected registered outputs (from a small behavioural reference) into a
// queue; a monitor process pops and compares on every falling edge.
// Directed checks with hand-computed constants cover the key milestones.
module tb_esync_monitor;

    typedef struct packed {
        logic       err;
        logic       lck;
        logic       rsy;
        logic       phs;
        logic [7:0] rcnt;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       sync_clr;
    logic       we;
    logic [3:0] stage;
    logic [2:0] metric;
    logic [2:0] thresh;
    logic       error;
    logic       locked;
    logic       resync;
    logic [0:0] phase;
    logic [7:0] resync_cnt;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // Reference model state
    int m_win, m_bad, m_good, m_state, m_phase, m_rcnt;
    bit m_err, m_resync;

    esync_monitor #(
        .METRIC_W  (3),
        .STAGE_W   (4),
        .MIN_STAGE (3),
        .WINDOW    (16),
        .ERR_LIMIT (4),
        .GOOD_WIN  (2),
        .NPHASE    (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sync_clr   (sync_clr),
        .we         (we),
        .stage      (stage),
        .metric     (metric),
        .thresh     (thresh),
        .error      (error),
        .locked     (locked),
        .resync     (resync),
        .phase      (phase),
        .resync_cnt (resync_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_win = 0; m_bad = 0; m_good = 0; m_state = 0;
        m_phase = 0; m_rcnt = 0; m_err = 0; m_resync = 0;
    endtask

    task automatic modelFail();
        m_phase  = (m_phase + 1) % 2;
        m_resync = 1;
        m_good   = 0;
        if (m_rcnt < 255) m_rcnt++;
    endtask

    task automatic modelStep(input logic w, input logic [3:0] st, input logic [2:0] m,
                             input logic [2:0] th, input logic sc);
        bit q, b, fl;
        if (sc) begin
            modelReset();
            return;
        end
        q = w && (int'(st) >= 3);
        b = q && (int'(m) > int'(th));
        m_err    = b;
        m_resync = 0;
        if (q) begin
            if (b && m_bad < 4) m_bad++;
            if (m_win == 15) begin
                fl = (m_bad >= 4);
                m_win = 0;
                m_bad = 0;
                case (m_state)
                    0: begin
                        if (fl) modelFail();
                        else begin
                            m_good++;
                            if (m_good == 2) begin
                                m_state = 1;
                                m_good  = 0;
                            end
                        end
                    end
                    1: if (fl) m_state = 2;
                    default: begin
                        if (fl) begin
                            m_state = 0;
                            modelFail();
                        end else m_state = 1;
                    end
                endcase
            end else begin
                m_win++;
            end
        end
    endtask

    // Drive one vector for one clock and record what the DUT must show after.
    task automatic applyStimulus(input logic w, input logic [3:0] st, input logic [2:0] m,
                                 input logic [2:0] th, input logic sc);
        exp_t e;
        @(negedge clock);
        we = w; stage = st; metric = m; thresh = th; sync_clr = sc;
        @(posedge clock);
        modelStep(w, st, m, th, sc);
        e.err  = m_err;
        e.lck  = (m_state != 0);
        e.rsy  = m_resync;
        e.phs  = m_phase[0];
        e.rcnt = 8'(m_rcnt);
        sb.push_back(e);
    endtask

    // Sixteen qualified samples, nbad of them bad, clustered at the end or start.
    task automatic sendWindow(input int nbad, input bit badLast, input logic [2:0] goodMetric);
        for (int i = 0; i < 16; i++) begin
            bit isBad;
            isBad = badLast ? (i >= 16 - nbad) : (i < nbad);
            applyStimulus(1'b1, 4'd3, isBad ? 3'd6 : goodMetric, 3'd5, 1'b0);
        end
    endtask

    // Hand-computed milestone check, just after the active edge has settled.
    task automatic handCheck(input string tag, input int e, input int l, input int r,
                             input int p, input int c);
        #1;
        checkOutput({tag, ".error"}, int'(error), e);
        checkOutput({tag, ".locked"}, int'(locked), l);
        checkOutput({tag, ".resync"}, int'(resync), r);
        checkOutput({tag, ".phase"}, int'(phase), p);
        checkOutput({tag, ".resync_cnt"}, int'(resync_cnt), c);
    endtask

    task automatic doReset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        handCheck("async_reset", 0, 0, 0, 0, 0);
        modelReset();
        we = 1'b0; sync_clr = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Scoreboard monitor: every falling edge with a pending expectation compares.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sb.error", int'(error), int'(e.err));
            checkOutput("sb.locked", int'(locked), int'(e.lck));
            checkOutput("sb.resync", int'(resync), int'(e.rsy));
            checkOutput("sb.phase", int'(phase), int'(e.phs));
            checkOutput("sb.resync_cnt", int'(resync_cnt), int'(e.rcnt));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; sync_clr = 1'b0; we = 1'b0;
        stage = 4'd0; metric = 3'd0; thresh = 3'd0;
        modelReset();
        #1;
        handCheck("reset", 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

        // Three clean windows: lock after the second close
        for (int w = 0; w < 3; w++) sendWindow(0, 1'b0, 3'd2);
        handCheck("lock_acquired", 0, 1, 0, 0, 0);

        // One failing window while locked: SUSPECT, still locked
        sendWindow(4, 1'b0, 3'd2);
        handCheck("suspect", 0, 1, 0, 0, 0);
        sendWindow(0, 1'b0, 3'd2);
        handCheck("relock", 0, 1, 0, 0, 0);

        // Two failing windows: lose lock with resync
        sendWindow(4, 1'b0, 3'd2);
        sendWindow(4, 1'b0, 3'd2);
        handCheck("lost_lock", 0, 0, 1, 1, 1);
        sendWindow(4, 1'b0, 3'd2);
        handCheck("phase_wrap", 0, 0, 1, 0, 2);

        // Limit boundary: 3 bad passes, 4 bad with bad closing sample fails
        sendWindow(3, 1'b1, 3'd2);
        handCheck("three_bad_pass", 1, 0, 0, 0, 2);
        sendWindow(4, 1'b1, 3'd2);
        handCheck("four_bad_fail", 1, 0, 1, 1, 3);
        sendWindow(0, 1'b0, 3'd5);
        handCheck("metric_eq_thresh", 0, 0, 0, 1, 3);

        // Non-qualified samples: early stage and no write strobe
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd2, 3'd7, 3'd5, 1'b0);
        handCheck("stage2_ignored", 0, 0, 0, 1, 3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd3, 3'd7, 3'd5, 1'b0);
        handCheck("we0_ignored", 0, 0, 0, 1, 3);
        applyStimulus(1'b1, 4'd3, 3'd7, 3'd5, 1'b0);
        handCheck("stage3_bad", 1, 0, 0, 1, 3);

        // Asynchronous reset mid-window, then a fresh window with no carry-over
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd3, 3'd2, 3'd5, 1'b0);
        applyStimulus(1'b1, 4'd3, 3'd6, 3'd5, 1'b0);
        doReset();
        sendWindow(4, 1'b1, 3'd2);
        handCheck("post_reset_window", 1, 0, 1, 1, 1);

        // sync_clr on a bad closing sample wins over the window failure
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 4'd3, 3'd6, 3'd5, 1'b0);
        applyStimulus(1'b1, 4'd3, 3'd6, 3'd5, 1'b1);
        handCheck("sync_clr", 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'd3, 3'd6, 3'd5, 1'b0);
        applyStimulus(1'b0, 4'd0, 3'd0, 3'd0, 1'b0);

        @(negedge clock);
        @(negedge clock);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
